// File: rtl/hello_scroll_writer.sv
// Message buffer with a valid/ready write port that scrolls its contents
// right-to-left across the DE2 HEX4..HEX0 digits, one position per timer tick.
module hello_scroll_writer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       wr_valid,
    input  logic [2:0] wr_char,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic       clear,
    input  logic       run,
    output logic       busy,
    output logic [2:0] pos,
    output logic [0:6] HEX4,
    output logic [0:6] HEX3,
    output logic [0:6] HEX2,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {EMPTY, LOAD, SCROLL} state_t;

    state_t        state;
    logic [2:0]    char_buf [8];
    logic [3:0]    len;
    logic [CW-1:0] cnt;
    logic [6:0]    hex_q [5];
    logic [6:0]    disp [5];
    logic [3:0]    idx;
    logic          accept;

    // Segment literals are written g..a, so bit 0 is segment a.
    function automatic logic [6:0] seg_of(input logic [2:0] code);
        case (code)
            3'b000:  seg_of = 7'b0001001;
            3'b001:  seg_of = 7'b0000110;
            3'b010:  seg_of = 7'b1000111;
            3'b011:  seg_of = 7'b1000000;
            default: seg_of = BLANK;
        endcase
    endfunction

    function automatic logic [0:6] to_port(input logic [6:0] s);
        logic [0:6] r;
        for (int i = 0; i < 7; i++) r[i] = s[i];
        return r;
    endfunction

    assign wr_ready = (state != SCROLL) && !clear;
    assign accept   = wr_valid && wr_ready;
    assign busy     = (state == SCROLL);

    // Digit k is HEX(4-k); pos+k never exceeds 11, so four conditional
    // subtractions cover the modulo even for len=1.
    always_comb begin
        idx = '0;
        for (int k = 0; k < 5; k++) begin
            disp[k] = BLANK;
            case (state)
                LOAD: begin
                    if (4'(k) < len) disp[k] = seg_of(char_buf[k]);
                end
                SCROLL: begin
                    idx = {1'b0, pos} + 4'(k);
                    for (int s = 0; s < 4; s++) begin
                        if (idx >= len) idx = idx - len;
                    end
                    disp[k] = seg_of(char_buf[idx[2:0]]);
                end
                default: disp[k] = BLANK;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= EMPTY;
            len   <= '0;
            pos   <= '0;
            cnt   <= '0;
            for (int k = 0; k < 5; k++) hex_q[k] <= BLANK;
        end else if (clear) begin
            // Blank immediately so the display agrees with the EMPTY state.
            state <= EMPTY;
            len   <= '0;
            pos   <= '0;
            cnt   <= '0;
            for (int k = 0; k < 5; k++) hex_q[k] <= BLANK;
        end else begin
            for (int k = 0; k < 5; k++) hex_q[k] <= disp[k];
            case (state)
                EMPTY: begin
                    cnt <= '0;
                    if (accept) begin
                        char_buf[0] <= wr_char;
                        len         <= 4'd1;
                        pos         <= '0;
                        state       <= wr_last ? SCROLL : LOAD;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    if (accept) begin
                        char_buf[len[2:0]] <= wr_char;
                        len                <= len + 4'd1;
                        pos                <= '0;
                        if (wr_last || len == 4'd7) state <= SCROLL;
                    end
                end
                SCROLL: begin
                    if (run) begin
                        if (cnt == CW'(TICK_DIV - 1)) begin
                            cnt <= '0;
                            pos <= ({1'b0, pos} + 4'd1 == len) ? 3'd0 : pos + 3'd1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign HEX4 = to_port(hex_q[0]);
    assign HEX3 = to_port(hex_q[1]);
    assign HEX2 = to_port(hex_q[2]);
    assign HEX1 = to_port(hex_q[3]);
    assign HEX0 = to_port(hex_q[4]);

endmodule

// File: tb/tb_hello_scroll_writer.sv
// Self-checking bench for hello_scroll_writer: directed scenarios followed by
// random traffic, all compared every cycle against a queue-based message model.
module tb_hello_scroll_writer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst, wr_valid, wr_last, clr, run;
    logic [2:0] wr_char;
    logic       wr_ready, busy;
    logic [2:0] pos;
    logic [0:6] h4, h3, h2, h1, h0;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: 0 = empty, 1 = loading, 2 = scrolling
    int          m_mode = 0;
    int          m_msg[$];
    int          m_pos = 0;
    int          m_cnt = 0;
    logic [34:0] m_hex = {35{1'b1}};

    always #5 clk = ~clk;

    hello_scroll_writer #(.TICK_DIV(TD)) dut (
        .CLOCK_50(clk), .Reset(rst), .wr_valid(wr_valid), .wr_char(wr_char),
        .wr_last(wr_last), .wr_ready(wr_ready), .clear(clr), .run(run),
        .busy(busy), .pos(pos), .HEX4(h4), .HEX3(h3), .HEX2(h2), .HEX1(h1), .HEX0(h0)
    );

    function automatic logic [6:0] seg(input int c);
        case (c)
            0:       return 7'b0001001;
            1:       return 7'b0000110;
            2:       return 7'b1000111;
            3:       return 7'b1000000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] unflip(input logic [0:6] h);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = h[i];
        return r;
    endfunction

    // Digits packed HEX4 first; each digit is the message char at (pos+k) mod len.
    function automatic logic [34:0] window();
        logic [34:0] r;
        r = {35{1'b1}};
        for (int k = 0; k < 5; k++) begin
            if (m_mode == 1 && k < m_msg.size())
                r[34-7*k -: 7] = seg(m_msg[k]);
            else if (m_mode == 2)
                r[34-7*k -: 7] = seg(m_msg[(m_pos + k) % m_msg.size()]);
        end
        return r;
    endfunction

    task automatic model_update();
        logic [34:0] nh;
        nh = (rst || clr) ? {35{1'b1}} : window();
        if (rst || clr) begin
            m_mode = 0; m_msg.delete(); m_pos = 0; m_cnt = 0;
        end else if (m_mode != 2 && wr_valid) begin
            m_msg.push_back(int'(wr_char));
            if (wr_last || m_msg.size() == 8) begin
                m_mode = 2; m_pos = 0; m_cnt = 0;
            end else begin
                m_mode = 1;
            end
        end else if (m_mode == 2 && run) begin
            if (m_cnt == TD - 1) begin
                m_cnt = 0;
                m_pos = (m_pos + 1) % m_msg.size();
            end else begin
                m_cnt++;
            end
        end
        m_hex = nh;
    endtask

    task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("hex", {unflip(h4), unflip(h3), unflip(h2), unflip(h1), unflip(h0)}, m_hex);
        check("pos", 35'(pos), 35'(m_pos));
        check("busy", 35'(busy), 35'(m_mode == 2));
        check("wr_ready", 35'(wr_ready), 35'(m_mode != 2 && !clr));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input int c, input logic last);
        wr_valid = 1'b1;
        wr_char  = 3'(c);
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; run = 1'b1;
        wr_valid = 1'b0; wr_char = 3'd0; wr_last = 1'b0;
        steps(2);
        check("reset_hex", {unflip(h4), unflip(h3), unflip(h2), unflip(h1), unflip(h0)}, {35{1'b1}});
        rst = 1'b0;
        step();

        // HELLO, then a full wrap plus a few extra steps
        write(0, 0); write(1, 0); write(2, 0); write(2, 0); write(3, 1);
        steps(24);

        // run=0 freeze mid-scroll, then resume
        steps(2);
        run = 1'b0; steps(10);
        run = 1'b1; steps(10);

        // Reset mid-scroll
        rst = 1'b1; step();
        rst = 1'b0; step();

        // Eight chars without last, then an ignored ninth write
        for (int i = 0; i < 8; i++) write(i, 0);
        write(1, 1);
        steps(40);

        // "HEL" wrap, clear coinciding with a tick
        clr = 1'b1; step(); clr = 1'b0;
        write(0, 0); write(1, 0); write(2, 1);
        steps(12);
        while (m_cnt != TD - 1) step();
        clr = 1'b1; step(); clr = 1'b0;
        steps(3);

        // clear with a write in LOAD, then a single-char message
        write(3, 0);
        clr = 1'b1; write(1, 0); clr = 1'b0;
        steps(2);
        write(1, 1);
        steps(10);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            clr      = ($urandom_range(0, 79) == 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_char  = 3'($urandom);
            wr_last  = ($urandom_range(0, 4) == 0);
            run      = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
